// File: rtl/als_saida_pkg.sv
// Shared types for the SAP-1 output register arbiter: FSM states, grant sources
// and the default data width.
package als_saida_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DBG = 1'b1
  } src_e;

endpackage

// File: rtl/als_fifo_saida.sv
// Synchronous FIFO queueing CPU OUT writes. A push while full is refused; full
// is judged on the pre-edge count, so a same-cycle pop cannot make room.
module als_fifo_saida #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_d,
  input  logic              pop,
  output logic [DATA_W-1:0] head_d,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head_d  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_d;
  end

endmodule

// File: rtl/als_output_register_arbiter.sv
// Shares the SAP-1 output register between the CPU write FIFO and, when
// DEBUG_PORT_EN is defined, a round-robin debug requester; enforces a dwell time.
module als_output_register_arbiter
  import als_saida_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_d,
  output logic              cpu_full,
  output logic              overflow,
`ifdef DEBUG_PORT_EN
  input  logic              dbg_req,
  input  logic [DATA_W-1:0] dbg_d,
  output logic              dbg_ack,
`endif
  output logic [DATA_W-1:0] out_d,
  output logic              out_n_write,
  output logic              busy
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [DATA_W-1:0] out_d_q, out_d_d;
  logic              n_write_q, n_write_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              cpu_pend;
  logic              dbg_pend;
  logic              grant_dbg;
  logic [DATA_W-1:0] grant_data;
  logic              grant;

  als_fifo_saida #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (cpu_wr),
    .push_d (cpu_d),
    .pop    ((state_q == ST_LOAD) && (src_q == SRC_CPU)),
    .head_d (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign cpu_pend = !fifo_empty;
  assign grant    = (state_q == ST_IDLE) && (cpu_pend || dbg_pend);

`ifdef DEBUG_PORT_EN
  logic last_dbg_q, last_dbg_d;
  logic ack_q, ack_d;

  // Debug wins a tie only when the previous grant went to the CPU.
  assign dbg_pend   = dbg_req;
  assign grant_dbg  = dbg_req && (!cpu_pend || !last_dbg_q);
  assign grant_data = grant_dbg ? dbg_d : fifo_head;

  always_comb begin
    last_dbg_d = last_dbg_q;
    ack_d      = 1'b0;
    if (grant) begin
      last_dbg_d = grant_dbg;
      ack_d      = grant_dbg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dbg_q <= 1'b1;
      ack_q      <= 1'b0;
    end else begin
      last_dbg_q <= last_dbg_d;
      ack_q      <= ack_d;
    end
  end

  assign dbg_ack = ack_q;
`else
  assign dbg_pend   = 1'b0;
  assign grant_dbg  = 1'b0;
  assign grant_data = fifo_head;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    out_d_d    = out_d_q;
    n_write_d  = 1'b1;
    hold_d     = hold_q;
    overflow_d = overflow_q || (cpu_wr && fifo_full);
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d   = ST_LOAD;
          n_write_d = 1'b0;
          src_d     = grant_dbg ? SRC_DBG : SRC_CPU;
          out_d_d   = grant_data;
        end
      end
      ST_LOAD: begin
        if (HOLD_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
          hold_d  = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_IDLE;
        else              hold_d  = hold_q - HC_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_CPU;
      out_d_q    <= '0;
      n_write_q  <= 1'b1;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      out_d_q    <= out_d_d;
      n_write_q  <= n_write_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
    end
  end

  assign cpu_full    = fifo_full;
  assign overflow    = overflow_q;
  assign out_d       = out_d_q;
  assign out_n_write = n_write_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
